// File: rtl/dm_pkg.sv
// dm_pkg: shared helpers for the pipelined data memory.
//   ofs_bits_f / idx_bits_f : derive byte-offset and word-index widths
//   OFS_BITS / IDX_BITS     : those widths for the default 32-bit x 32-word build
//   byte_merge              : one byte lane of a write-first merge
//   rd_slot_t               : {valid, error, data} read-pipeline slot (default width)
package dm_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 32;

  function automatic int ofs_bits_f(input int data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 0;
  endfunction

  function automatic int idx_bits_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int OFS_BITS = ofs_bits_f(DEF_DATA_WIDTH);
  localparam int IDX_BITS = idx_bits_f(DEF_DEPTH);

  // Merge is defined per byte lane so it works for any DATA_WIDTH; the
  // caller applies it across all lanes of a word.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

  // Slot layout for the default width; dm_read_pipe rebuilds the same
  // layout at its own DATA_WIDTH.
  typedef struct packed {
    logic                      valid;
    logic                      error;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rd_slot_t;

endpackage

// File: rtl/dm_read_pipe.sv
// dm_read_pipe: LATENCY-stage delay line of {valid, error, data} slots.
//   clk, rst (async, active-high)
//   in_valid/in_error/in_data    : slot launched at the current edge
//   out_valid/out_error/out_data : slot leaving the last stage
// A stage's data only loads when the slot behind it is valid, so out_data
// holds the last delivered value while out_valid is low.
module dm_read_pipe
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_error,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_error,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef struct packed {
    logic                  valid;
    logic                  error;
    logic [DATA_WIDTH-1:0] data;
  } slot_t;

  slot_t stage_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0].valid <= in_valid;
      stage_q[0].error <= in_error;
      if (in_valid) stage_q[0].data <= in_data;
      for (int k = 1; k < LATENCY; k++) begin
        stage_q[k].valid <= stage_q[k-1].valid;
        stage_q[k].error <= stage_q[k-1].error;
        if (stage_q[k-1].valid) stage_q[k].data <= stage_q[k-1].data;
      end
    end
  end

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_error = stage_q[LATENCY-1].error;
  assign out_data  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: byte-addressed data memory for the MEM stage.
//   clk, rst (async, active-high)
//   Mem_read, Mem_write, Mem_address : request (one shared byte address)
//   Write_data, Byte_en              : store data and per-byte enables
//   Read_Data, Read_valid            : load response, READ_LATENCY after request
//   Mem_error                        : fault strobe in the response slot
// Handshake: there is no ready. Every request sampled on a rising edge is
// accepted; Read_valid is a one-cycle strobe per accepted read and the
// consumer cannot stall it. Read_Data is meaningful only with Read_valid.
module data_memory_pipelined
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Mem_read,
  input  logic                    Mem_write,
  input  logic [ADDR_WIDTH-1:0]   Mem_address,
  input  logic [DATA_WIDTH-1:0]   Write_data,
  input  logic [DATA_WIDTH/8-1:0] Byte_en,
  output logic [DATA_WIDTH-1:0]   Read_Data,
  output logic                    Read_valid,
  output logic                    Mem_error
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = ofs_bits_f(DATA_WIDTH);
  localparam int IDX = idx_bits_f(DEPTH);

  // Array contents are never reset; written_q masks stale words instead.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]        written_q;
  logic                    wr_err_q;

  logic [ADDR_WIDTH-OFS-1:0] word_sel;
  logic [IDX-1:0]            idx;
  logic                      misaligned;
  logic                      out_of_range;
  logic                      fault;
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     base_word;
  logic [DATA_WIDTH-1:0]     merged_word;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic                      pipe_error;

  assign word_sel     = Mem_address[ADDR_WIDTH-1:OFS];
  assign idx          = word_sel[IDX-1:0];
  assign out_of_range = (word_sel >= (ADDR_WIDTH-OFS)'(DEPTH));

  generate
    if (OFS > 0) begin : g_align
      assign misaligned = |Mem_address[OFS-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  assign fault = misaligned | out_of_range;
  // An all-zero Byte_en is a no-op and must not mark the word written.
  assign wr_en = Mem_write & ~fault & (|Byte_en);

  // Unwritten words read as zero, so partial writes zero-fill other lanes.
  assign base_word = written_q[idx] ? mem_q[idx] : '0;

  always_comb begin
    merged_word = base_word;
    for (int i = 0; i < NB; i++) begin
      merged_word[8*i +: 8] = byte_merge(base_word[8*i +: 8], Write_data[8*i +: 8], Byte_en[i]);
    end
  end

  // Write-first: a same-cycle write to the same word is visible to the read.
  assign rd_word = fault ? '0 : (wr_en ? merged_word : base_word);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= merged_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      if (wr_en) written_q[idx] <= 1'b1;
      // A faulting read+write reports once, in the read slot.
      wr_err_q <= Mem_write & ~Mem_read & fault;
    end
  end

  dm_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (Mem_read),
    .in_error  (Mem_read & fault),
    .in_data   (rd_word),
    .out_valid (Read_valid),
    .out_error (pipe_error),
    .out_data  (Read_Data)
  );

  assign Mem_error = pipe_error | wr_err_q;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: four configurations, each with its own
// word-array reference model and response queue checked every cycle.
module tb_data_memory_pipelined;

  localparam int NCFG = 4;

  function automatic int cfg_dw(input int k);
    case (k)
      0: return 32;
      1: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_depth(input int k);
    case (k)
      0: return 32;
      1: return 16;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_lat(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- per-configuration DUT, model, scoreboard ----------------
  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int DW    = cfg_dw(g);
    localparam int DEPTH = cfg_depth(g);
    localparam int L     = cfg_lat(g);
    localparam int NB    = DW / 8;

    logic          rst = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [31:0]   mem_address = '0;
    logic [DW-1:0] write_data = '0;
    logic [NB-1:0] byte_en = '0;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          mem_error;

    logic [DW-1:0] model [DEPTH];
    logic [32+DW:0] exp_q [$];   // {due cycle, error, data}
    int            we_q [$];     // due cycles of write-only fault strobes
    logic [DW-1:0] last_data = '0;
    bit            armed = 1'b0;

    data_memory_pipelined #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .ADDR_WIDTH   (32),
      .READ_LATENCY (L)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .Mem_read    (mem_read),
      .Mem_write   (mem_write),
      .Mem_address (mem_address),
      .Write_data  (write_data),
      .Byte_en     (byte_en),
      .Read_Data   (read_data),
      .Read_valid  (read_valid),
      .Mem_error   (mem_error)
    );

    // Drive one request for the coming edge, predict its response, then
    // advance to the next falling edge.
    task automatic drive(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [DW-1:0] wd, input logic [NB-1:0] be);
      int            e;
      int            idx;
      bit            fault;
      logic [DW-1:0] rv;
      e = cyc + 1;
      mem_read    = rd;
      mem_write   = wr;
      mem_address = addr;
      write_data  = wd;
      byte_en     = be;
      fault = ((addr % NB) != 0) || ((addr / NB) >= DEPTH);
      idx   = fault ? 0 : int'(addr / NB);
      if (wr && !fault) begin
        for (int i = 0; i < NB; i++) if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
      end
      rv = fault ? '0 : model[idx];
      if (rd) exp_q.push_back({32'(e + L - 1), fault, rv});
      else if (wr && fault) we_q.push_back(e);
      @(negedge clk);
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
      #1;
      rst       = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      exp_q.delete();
      we_q.delete();
      last_data = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      armed = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    endtask

    task automatic run_random(input int n);
      logic [31:0]   addr;
      logic [DW-1:0] wd;
      logic [NB-1:0] be;
      int            kind;
      do_reset();
      for (int t = 0; t < n; t++) begin
        if (t == n / 2) do_reset();
        addr = 32'($urandom_range(0, DEPTH + 1) * NB);
        if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, NB - 1));
        for (int i = 0; i < NB; i++) begin
          wd[8*i +: 8] = 8'($urandom_range(0, 255));
          be[i]        = 1'($urandom_range(0, 1));
        end
        kind = $urandom_range(0, 9);
        if (kind < 4)      drive(1'b1, 1'b0, addr, wd, be);
        else if (kind < 7) drive(1'b0, 1'b1, addr, wd, be);
        else if (kind < 9) drive(1'b1, 1'b1, addr, wd, be);
        else               idle(1);
      end
      idle(L + 2);
      total++;
      if (exp_q.size() != 0 || we_q.size() != 0) begin
        bad++;
        $display("FAIL cfg%0d drain: pending reads=%0d writes=%0d required 0", g, exp_q.size(), we_q.size());
      end
    endtask

    // Scoreboard: every cycle the outputs must match what is due now.
    always @(negedge clk) begin : mon
      bit            rd_due;
      bit            we_due;
      bit            exp_err;
      logic [DW-1:0] exp_data;
      if (armed) begin
        rd_due   = (exp_q.size() > 0) && (int'(exp_q[0][32+DW:DW+1]) == cyc);
        we_due   = (we_q.size() > 0) && (we_q[0] == cyc);
        exp_err  = (rd_due && exp_q[0][DW]) || we_due;
        exp_data = rd_due ? exp_q[0][DW-1:0] : last_data;
        total++;
        if (read_valid !== rd_due) begin
          bad++;
          $display("FAIL cfg%0d read_valid cyc=%0d got=%b required=%b", g, cyc, read_valid, rd_due);
        end
        total++;
        if (mem_error !== exp_err) begin
          bad++;
          $display("FAIL cfg%0d mem_error cyc=%0d got=%b required=%b", g, cyc, mem_error, exp_err);
        end
        total++;
        if (read_data !== exp_data) begin
          bad++;
          $display("FAIL cfg%0d read_data cyc=%0d got=%h required=%h", g, cyc, read_data, exp_data);
        end
        last_data = exp_data;
        if (rd_due) void'(exp_q.pop_front());
        if (we_due) void'(we_q.pop_front());
      end
    end
  end

  // ---------------- directed scenarios on cfg0 (32-bit, 32 words, latency 2) ----------------
  task automatic test_reset();
    cfg[0].do_reset();
    total++;
    if (cfg[0].read_valid !== 1'b0 || cfg[0].mem_error !== 1'b0 || cfg[0].read_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b err=%b data=%h required 0/0/0",
               cfg[0].read_valid, cfg[0].mem_error, cfg[0].read_data);
    end
  endtask

  task automatic test_unwritten_read();
    cfg[0].drive(1'b1, 1'b0, 32'h14, '0, '0);
    total++;
    if (cfg[0].read_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_valid got=%b required=0", cfg[0].read_valid);
    end
    cfg[0].idle(1);
    total++;
    if (cfg[0].read_valid !== 1'b1 || cfg[0].read_data !== 32'h0 || cfg[0].mem_error !== 1'b0) begin
      bad++;
      $display("FAIL unwritten_read got valid=%b data=%h err=%b required 1/00000000/0",
               cfg[0].read_valid, cfg[0].read_data, cfg[0].mem_error);
    end
  endtask

  task automatic test_byte_write();
    cfg[0].drive(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'b1111);
    cfg[0].drive(1'b0, 1'b1, 32'h08, 32'h000000AA, 4'b0001);
    cfg[0].drive(1'b1, 1'b0, 32'h08, '0, '0);
    cfg[0].idle(1);
    total++;
    if (cfg[0].read_valid !== 1'b1 || cfg[0].read_data !== 32'hDEADBEAA) begin
      bad++;
      $display("FAIL byte_write got valid=%b data=%h required 1/deadbeaa", cfg[0].read_valid, cfg[0].read_data);
    end
  endtask

  task automatic test_forward();
    cfg[0].drive(1'b1, 1'b1, 32'h10, 32'h12345678, 4'b1100);
    cfg[0].idle(1);
    total++;
    if (cfg[0].read_valid !== 1'b1 || cfg[0].read_data !== 32'h12340000) begin
      bad++;
      $display("FAIL forward got valid=%b data=%h required 1/12340000", cfg[0].read_valid, cfg[0].read_data);
    end
  endtask

  task automatic test_faults();
    cfg[0].drive(1'b1, 1'b0, 32'h03, '0, '0);
    cfg[0].drive(1'b1, 1'b0, 32'h80, '0, '0);
    total++;
    if (cfg[0].read_valid !== 1'b1 || cfg[0].mem_error !== 1'b1 || cfg[0].read_data !== 32'h0) begin
      bad++;
      $display("FAIL misaligned_read got valid=%b err=%b data=%h required 1/1/0",
               cfg[0].read_valid, cfg[0].mem_error, cfg[0].read_data);
    end
    cfg[0].idle(1);
    total++;
    if (cfg[0].read_valid !== 1'b1 || cfg[0].mem_error !== 1'b1 || cfg[0].read_data !== 32'h0) begin
      bad++;
      $display("FAIL range_read got valid=%b err=%b data=%h required 1/1/0",
               cfg[0].read_valid, cfg[0].mem_error, cfg[0].read_data);
    end
    cfg[0].drive(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 4'b1111);
    total++;
    if (cfg[0].mem_error !== 1'b1 || cfg[0].read_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_fault got err=%b valid=%b required 1/0", cfg[0].mem_error, cfg[0].read_valid);
    end
    cfg[0].idle(1);
    total++;
    if (cfg[0].mem_error !== 1'b0) begin
      bad++;
      $display("FAIL write_fault_len got err=%b required 0", cfg[0].mem_error);
    end
    // Every word must still hold its earlier value; the scoreboard checks each.
    for (int i = 0; i < 32; i++) cfg[0].drive(1'b1, 1'b0, 32'(i * 4), '0, '0);
    cfg[0].idle(2);
  endtask

  task automatic test_reset_in_flight();
    int strobes;
    for (int i = 0; i < 4; i++) cfg[0].drive(1'b1, 1'b0, 32'(i * 4), '0, '0);
    cfg[0].do_reset();
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      if (cfg[0].read_valid === 1'b1 || cfg[0].mem_error === 1'b1) strobes++;
      cfg[0].idle(1);
    end
    total++;
    if (strobes != 0) begin
      bad++;
      $display("FAIL post_reset_strobes got=%0d required=0", strobes);
    end
    cfg[0].drive(1'b1, 1'b0, 32'h08, '0, '0);
    cfg[0].idle(1);
    total++;
    if (cfg[0].read_valid !== 1'b1 || cfg[0].read_data !== 32'h0) begin
      bad++;
      $display("FAIL read_after_reset got valid=%b data=%h required 1/0", cfg[0].read_valid, cfg[0].read_data);
    end
    for (int i = 0; i < 32; i++) cfg[0].drive(1'b1, 1'b0, 32'(i * 4), '0, '0);
    cfg[0].idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cfg[0].drive(1'b0, 1'b1, 32'(i * 4), 32'($urandom), 4'b1111);
    for (int i = 0; i < 8; i++) cfg[0].drive(1'b1, 1'b0, 32'(i * 4), '0, '0);
    cfg[0].idle(3);
    total++;
    if (cfg[0].exp_q.size() != 0) begin
      bad++;
      $display("FAIL back_to_back pending=%0d required=0", cfg[0].exp_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unwritten_read();
    test_byte_write();
    test_forward();
    test_faults();
    test_reset_in_flight();
    test_back_to_back();
    cfg[0].run_random(400);
    cfg[1].run_random(400);
    cfg[2].run_random(400);
    cfg[3].run_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
